// File: rtl/hazard_scoreboard.sv
// Destination-register scoreboard for the ID/EX, EX/MEM and MEM/WB slots:
// feeds the forwarding unit, detects load-use hazards, handles flush and memory freeze.
module hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                id_valid_i,
    input  logic [REG_AW-1:0]   id_rs1_i,
    input  logic [REG_AW-1:0]   id_rs2_i,
    input  logic                id_uses_rs1_i,
    input  logic                id_uses_rs2_i,
    input  logic [REG_AW-1:0]   id_rd_i,
    input  logic                id_regwrite_i,
    input  logic                id_memread_i,
    input  logic                flush_i,
    input  logic                mem_ready_i,
    output logic                stall_id_o,
    output logic                bubble_ex_o,
    output logic [REG_AW-1:0]   ex_mem_rd_o,
    output logic                ex_mem_regwrite_o,
    output logic [REG_AW-1:0]   mem_wb_rd_o,
    output logic                mem_wb_regwrite_o,
    output logic [NUM_REGS-1:0] pending_mask_o,
    output logic [CNT_W-1:0]    stall_count_o
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } idExSlot_t;

    // The load flag is only consulted while the producer sits in ID/EX.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
    } lateSlot_t;

    idExSlot_t        s1_q, s1_d;
    lateSlot_t        s2_q, s2_d;
    lateSlot_t        s3_q, s3_d;
    logic [CNT_W-1:0] stallCount_q, stallCount_d;

    logic      rs1Hit;
    logic      rs2Hit;
    logic      loadUse;
    logic      rdNonZero;
    idExSlot_t idEntry;

    always_comb begin
        rs1Hit  = id_uses_rs1_i && (id_rs1_i == s1_q.rd);
        rs2Hit  = id_uses_rs2_i && (id_rs2_i == s1_q.rd);
        loadUse = id_valid_i && s1_q.valid && s1_q.memread && s1_q.regwrite &&
                  (s1_q.rd != '0) && (rs1Hit || rs2Hit);
    end

    assign stall_id_o  = (loadUse && !flush_i) || !mem_ready_i;
    assign bubble_ex_o = mem_ready_i && (loadUse || flush_i || !id_valid_i);

    // Writes to x0 are dropped at capture so they never look like producers.
    always_comb begin
        rdNonZero        = (id_rd_i != '0);
        idEntry.valid    = 1'b1;
        idEntry.rd       = id_rd_i;
        idEntry.regwrite = id_regwrite_i && rdNonZero;
        idEntry.memread  = id_memread_i && rdNonZero;
    end

    always_comb begin
        s1_d         = s1_q;
        s2_d         = s2_q;
        s3_d         = s3_q;
        stallCount_d = stallCount_q;
        if (mem_ready_i) begin
            s3_d = s2_q;
            s2_d = '{valid: s1_q.valid, rd: s1_q.rd, regwrite: s1_q.regwrite};
            s1_d = '0;
            if (id_valid_i && !loadUse && !flush_i) begin
                s1_d = idEntry;
            end
            if (loadUse && !flush_i && (stallCount_q != '1)) begin
                stallCount_d = stallCount_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q         <= '0;
            s2_q         <= '0;
            s3_q         <= '0;
            stallCount_q <= '0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            stallCount_q <= stallCount_d;
        end
    end

    assign ex_mem_rd_o       = s2_q.valid ? s2_q.rd : '0;
    assign ex_mem_regwrite_o = s2_q.valid && s2_q.regwrite;
    assign mem_wb_rd_o       = s3_q.valid ? s3_q.rd : '0;
    assign mem_wb_regwrite_o = s3_q.valid && s3_q.regwrite;
    assign stall_count_o     = stallCount_q;

    always_comb begin
        pending_mask_o = '0;
        if (s1_q.valid && s1_q.regwrite) pending_mask_o[s1_q.rd] = 1'b1;
        if (s2_q.valid && s2_q.regwrite) pending_mask_o[s2_q.rd] = 1'b1;
        if (s3_q.valid && s3_q.regwrite) pending_mask_o[s3_q.rd] = 1'b1;
        pending_mask_o[0] = 1'b0;
    end

endmodule
